load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter EXT_WIDTH, default 32; data and address width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit; single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit; MEM-stage access request, held stable while stall=1.
REQ-005 SHALL have port req_we, input, 1 bit; 1=store, 0=load.
REQ-006 SHALL have port funct3, input, 3 bits; encodes LB=0, LH=1, LW=2, LBU=4, LHU=5; stores use SB=0, SH=1, SW=2.
REQ-007 SHALL have port addr, input, 32 bits; byte address.
REQ-008 SHALL have port wdata, input, 32 bits; store data, low bits significant.
REQ-009 SHALL have port stall, output, 1 bit; pipeline freeze.
REQ-010 SHALL have port done, output, 1 bit; one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32 bits; extended load result.
REQ-012 SHALL have port err, output, 1 bit; illegal-access flag, valid with done.
REQ-013 SHALL have port mem_A, output, 32 bits; data memory address.
REQ-014 SHALL have port mem_WD, output, 32 bits; data memory write data.
REQ-015 SHALL have port mem_WE, output, 1 bit; data memory write enable.
REQ-016 SHALL have port mem_RD, input, 32 bits; combinational data memory read of bytes A..A+3, little-endian.

Function
REQ-017 SHALL implement FSM states IDLE, RMW_WRITE and DONE.
REQ-018 In IDLE with req_valid=1, SHALL latch addr, funct3, wdata and req_we, and drive mem_A=addr.
REQ-019 For a load in IDLE, SHALL register the extended mem_RD into rdata, then go to DONE (load latency: done in cycle 2).
REQ-020 Load extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes all 32 bits.
REQ-021 For SW in IDLE, SHALL assert mem_WE=1 with mem_WD=wdata, then go to DONE.
REQ-022 For SB/SH in IDLE, SHALL capture mem_RD into a merge register, then go to RMW_WRITE.
REQ-023 In RMW_WRITE, SHALL drive the latched address, mem_WE=1 and mem_WD = merge with bits [7:0] (SB) or [15:0] (SH) replaced from latched wdata, then go to DONE.
REQ-024 In DONE, SHALL drive done=1 for exactly one cycle and return to IDLE; req_valid during DONE is ignored and accepted on the next IDLE cycle.
REQ-025 stall SHALL equal req_valid AND (state != DONE), combinationally.
REQ-026 mem_WE SHALL be 0 in every cycle except the single write cycle of a store.
REQ-027 funct3 values 3, 6 and 7 (and 4 or 5 with req_we=1) SHALL be illegal: no memory write, rdata=0, err=1 with done.
REQ-028 rdata SHALL hold its value until the next load completes; a store SHALL leave it unchanged.
REQ-029 mem_A SHALL equal addr in IDLE and the latched address otherwise.

Reset
REQ-030 rst=1 at a clock edge SHALL force state IDLE, rdata=0, done=0, err=0 and clear the latches.
REQ-031 rst asserted in RMW_WRITE SHALL abort the write: mem_WE=0 in the reset cycle and after it, and memory is unchanged.

Configuration
REQ-032 With macro LSU_ALIGN_CHECK_EN defined, SHALL treat halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 as illegal per REQ-027.
REQ-033 Without LSU_ALIGN_CHECK_EN, SHALL perform unaligned accesses as byte-contiguous operations at addr..addr+3, and err SHALL only flag illegal funct3.

Verification
REQ-034 mem bytes 0x100..0x103 = 80 7F 00 FF; LB at 0x100 -> rdata=0xFFFFFF80, done in cycle 2, stall high for cycle 1 only.
REQ-035 Same memory; LHU at 0x100 -> rdata=0x00007F80; LW -> 0xFF007F80.
REQ-036 Word 0x11223344 at 0x200; SB wdata=0xAB -> single mem_WE in cycle 2 with mem_WD=0x112233AB; done in cycle 3.
REQ-037 SW 0xDEADBEEF at 0x204 -> mem_WE in cycle 1 only, done in cycle 2, rdata unchanged.
REQ-038 SH started and rst asserted in the RMW_WRITE cycle -> mem_WE=0, memory unchanged, state IDLE, done=0.
REQ-039 With LSU_ALIGN_CHECK_EN, LW at 0x102 -> err=1 with done, rdata=0, no write; without it, LW at 0x102 returns bytes 0x102..0x105.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage: extended loads, word stores, read-modify-write SB/SH.
// Optional macro LSU_ALIGN_CHECK_EN flags misaligned halfword/word accesses as illegal.
module load_store_unit #(
  parameter int EXT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [2:0]           funct3,
  input  logic [EXT_WIDTH-1:0] addr,
  input  logic [EXT_WIDTH-1:0] wdata,
  output logic                 stall,
  output logic                 done,
  output logic [EXT_WIDTH-1:0] rdata,
  output logic                 err,
  output logic [EXT_WIDTH-1:0] mem_A,
  output logic [EXT_WIDTH-1:0] mem_WD,
  output logic                 mem_WE,
  input  logic [EXT_WIDTH-1:0] mem_RD
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RMW_WRITE = 2'd1;
  localparam logic [1:0] DONE      = 2'd2;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  logic [1:0]           r_state;
  logic [EXT_WIDTH-1:0] r_addr;
  logic [2:0]           r_funct3;
  logic [EXT_WIDTH-1:0] r_wdata;
  logic                 r_we;
  logic [EXT_WIDTH-1:0] r_merge;
  logic [EXT_WIDTH-1:0] r_rdata;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_illegal_f3;
  logic                 w_misaligned;
  logic                 w_illegal;
  logic                 w_is_sw;
  logic [EXT_WIDTH-1:0] w_load_ext;
  logic [EXT_WIDTH-1:0] w_merged;

  assign w_accept = (r_state == IDLE) && req_valid;

  // Unsigned-extension encodings only exist for loads.
  always_comb begin
    w_illegal_f3 = 1'b0;
    case (funct3)
      3'd3, 3'd6, 3'd7: w_illegal_f3 = 1'b1;
      F3_BU, F3_HU:     w_illegal_f3 = req_we;
      default:          w_illegal_f3 = 1'b0;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_illegal = w_illegal_f3 || w_misaligned;
  assign w_is_sw   = req_we && (funct3 == F3_W);

  always_comb begin
    w_load_ext = '0;
    case (funct3)
      F3_B:    w_load_ext = {{(EXT_WIDTH-8){mem_RD[7]}}, mem_RD[7:0]};
      F3_H:    w_load_ext = {{(EXT_WIDTH-16){mem_RD[15]}}, mem_RD[15:0]};
      F3_W:    w_load_ext = mem_RD;
      F3_BU:   w_load_ext = {{(EXT_WIDTH-8){1'b0}}, mem_RD[7:0]};
      F3_HU:   w_load_ext = {{(EXT_WIDTH-16){1'b0}}, mem_RD[15:0]};
      default: w_load_ext = '0;
    endcase
  end

  assign w_merged = (r_funct3 == F3_B) ? {r_merge[EXT_WIDTH-1:8], r_wdata[7:0]}
                                       : {r_merge[EXT_WIDTH-1:16], r_wdata[15:0]};

  assign stall  = req_valid && (r_state != DONE);
  assign done   = (r_state == DONE);
  assign err    = done && r_err;
  assign rdata  = r_rdata;
  assign mem_A  = (r_state == IDLE) ? addr : r_addr;
  assign mem_WD = (r_state == RMW_WRITE) ? w_merged : wdata;

  // Reset gates the write in the same cycle so an interrupted RMW never lands.
  assign mem_WE = !rst && ((w_accept && w_is_sw && !w_illegal) ||
                           ((r_state == RMW_WRITE) && r_we));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr   <= addr;
            r_funct3 <= funct3;
            r_wdata  <= wdata;
            r_we     <= req_we;
            r_err    <= w_illegal;
            if (w_illegal) begin
              r_rdata <= '0;
              r_state <= DONE;
            end else if (!req_we) begin
              r_rdata <= w_load_ext;
              r_state <= DONE;
            end else if (w_is_sw) begin
              r_state <= DONE;
            end else begin
              r_merge <= mem_RD;
              r_state <= RMW_WRITE;
            end
          end
        end
        RMW_WRITE: r_state <= DONE;
        DONE:      r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

endmodule
